// File: rtl/cory_burst_repeat.sv
// cory_burst_repeat: captures one burst while passing it through, then replays it from a buffer for the remaining passes.
module cory_burst_repeat #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int D  = 16,
  parameter int LW = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_cmd_v,
  input  logic [W-1:0]  i_cmd_cnt,
  input  logic [LW-1:0] i_cmd_len,
  output logic          o_cmd_r,
  input  logic          i_a_v,
  input  logic [N-1:0]  i_a_d,
  output logic          o_a_r,
  output logic          o_z_v,
  output logic [N-1:0]  o_z_d,
  output logic          o_z_last,
  output logic          o_z_blast,
  output logic [W-1:0]  o_z_cnt,
  output logic [LW-1:0] o_z_idx,
  input  logic          i_z_r,
  output logic          o_err
);
  typedef enum logic [2:0] {IDLE, PASS, REPLAY, DRAIN, ERR} state_t;
  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam logic [LW-1:0] DMAX = LW'(D);
  state_t state_q;
  logic [W-1:0] cnt_q, pass_q;
  logic [LW-1:0] len_q, idx_q;
  logic [N-1:0] buf_q [D];
  logic hs, wrap, fin, done;
  always_comb begin
    hs   = state_q == PASS ? i_a_v & i_z_r : state_q == REPLAY ? i_z_r : (state_q == DRAIN) & i_a_v;
    wrap = idx_q == len_q - LW'(1);
    fin  = pass_q == cnt_q - W'(1);
    // a drain has no passes, so its only wrap is also its completion
    done = hs & wrap & (fin | (state_q == DRAIN));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      pass_q  <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (i_cmd_v) begin
          cnt_q   <= i_cmd_cnt;
          len_q   <= i_cmd_len;
          pass_q  <= '0;
          idx_q   <= '0;
          state_q <= (i_cmd_len == '0 || i_cmd_len > DMAX) ? ERR : (i_cmd_cnt == '0 ? DRAIN : PASS);
        end
        ERR: state_q <= IDLE;
        default: if (hs) begin
          idx_q <= wrap ? '0 : idx_q + LW'(1);
          if (wrap) begin
            pass_q  <= done ? '0 : pass_q + W'(1);
            state_q <= done ? IDLE : REPLAY;
          end
        end
      endcase
    end
  always_ff @(posedge clk)
    if (state_q == PASS && hs) buf_q[idx_q[AW-1:0]] <= i_a_d;
  assign o_z_v     = state_q == PASS ? i_a_v : state_q == REPLAY;
  assign o_z_d     = state_q == PASS ? i_a_d : state_q == REPLAY ? buf_q[idx_q[AW-1:0]] : '0;
  assign o_a_r     = state_q == PASS ? i_z_r : state_q == DRAIN;
  assign o_z_last  = o_z_v & wrap;
  assign o_z_blast = o_z_last & fin;
  assign o_cmd_r   = done | (state_q == ERR);
  assign o_err     = state_q == ERR;
  assign o_z_cnt   = pass_q;
  assign o_z_idx   = idx_q;
endmodule
